// File: rtl/eq_pkg.sv
// Shared types and constants for the equaliser scale/sum scheduler.
package eq_pkg;

    localparam int unsigned NUM_BANDS  = 5;
    localparam int unsigned AUD_W      = 16;
    localparam int unsigned POT_W      = 12;
    localparam int unsigned ACC_W      = 19;
    localparam int unsigned BAND_SHIFT = 11;
    localparam int unsigned COEF_W     = POT_W + 1;
    localparam int unsigned PROD_W     = AUD_W + COEF_W;
    localparam int unsigned VOL_SHIFT  = 12;
    localparam int unsigned NUM_PROD   = 2 * NUM_BANDS;

    localparam logic signed [PROD_W-1:0] AUD_MAX = PROD_W'(32767);
    localparam logic signed [PROD_W-1:0] AUD_MIN = PROD_W'(-32768);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCALE,
        ST_DRAIN,
        ST_VOL,
        ST_VDRAIN
    } state_t;

    typedef enum logic [2:0] {
        BAND_LP,
        BAND_B1,
        BAND_B2,
        BAND_B3,
        BAND_HP
    } band_t;

    // Clamp a wide signed value into the signed audio range.
    function automatic logic signed [AUD_W-1:0] sat_aud(input logic signed [PROD_W-1:0] x);
        if (x > AUD_MAX) begin
            return 16'sh7fff;
        end else if (x < AUD_MIN) begin
            return 16'sh8000;
        end else begin
            return AUD_W'(x);
        end
    endfunction

endpackage

// File: rtl/eq_mult.sv
// Shared 16x13 signed multiplier with one registered output stage.
module eq_mult
    import eq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [AUD_W-1:0]  a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [PROD_W-1:0] p
);

    // Registered product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            p <= a * b;
        end
    end

endmodule

// File: rtl/eq_scale_sched.sv
// Equaliser band scaling, summation and master volume on one shared multiplier.
// Build option: define EQ_SAT_EN to saturate the band sums to 16 bits before the
// volume multiply; otherwise the sums wrap to their low 16 bits.
module eq_scale_sched
    import eq_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          smpl_rdy,
    input  logic [NUM_BANDS*AUD_W-1:0]    band_lft,
    input  logic [NUM_BANDS*AUD_W-1:0]    band_rght,
    input  logic [NUM_BANDS*POT_W-1:0]    POT_GAIN,
    input  logic [POT_W-1:0]              POT_VOL,
    output logic signed [AUD_W-1:0]       aud_out_lft,
    output logic signed [AUD_W-1:0]       aud_out_rght,
    output logic                          out_vld,
    output logic                          busy,
    output logic                          ovr
);

    state_t                       state;
    logic [3:0]                   cnt;
    logic [NUM_BANDS*AUD_W-1:0]   band_lft_h;
    logic [NUM_BANDS*AUD_W-1:0]   band_rght_h;
    logic [NUM_BANDS*POT_W-1:0]   gain_h;
    logic [POT_W-1:0]             vol_h;
    logic signed [ACC_W-1:0]      acc_l;
    logic signed [ACC_W-1:0]      acc_r;
    logic                         mv_q;
    logic                         mch_q;
    logic                         pend;
    logic signed [AUD_W-1:0]      hold_l;
    logic signed [AUD_W-1:0]      hold_r;

    band_t                        band_c;
    logic [6:0]                   aud_off;
    logic [5:0]                   gain_off;
    logic signed [AUD_W-1:0]      sum_l;
    logic signed [AUD_W-1:0]      sum_r;
    logic signed [AUD_W-1:0]      mul_a;
    logic signed [COEF_W-1:0]     mul_b;
    logic signed [PROD_W-1:0]     prod;
    logic signed [AUD_W-1:0]      band_scaled;
    logic                         accept_c;

    assign band_c   = band_t'(cnt[3:1]);
    assign aud_off  = 7'(band_c) * 7'(AUD_W);
    assign gain_off = 6'(band_c) * 6'(POT_W);
    assign accept_c = smpl_rdy && (state == ST_IDLE) && !busy;

`ifdef EQ_SAT_EN
    assign sum_l = sat_aud(PROD_W'(acc_l));
    assign sum_r = sat_aud(PROD_W'(acc_r));
`else
    assign sum_l = acc_l[AUD_W-1:0];
    assign sum_r = acc_r[AUD_W-1:0];
`endif

    assign band_scaled = sat_aud(prod >>> BAND_SHIFT);

    // Multiplier operand select: band gains during SCALE, master volume during VOL.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_SCALE: begin
                mul_a = cnt[0] ? band_rght_h[aud_off +: AUD_W] : band_lft_h[aud_off +: AUD_W];
                mul_b = {1'b0, gain_h[gain_off +: POT_W]};
            end
            ST_VOL: begin
                mul_a = cnt[0] ? sum_r : sum_l;
                mul_b = {1'b0, vol_h};
            end
            default: ;
        endcase
    end

    eq_mult u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (mul_a),
        .b     (mul_b),
        .p     (prod)
    );

    // Sequencer, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            band_lft_h   <= '0;
            band_rght_h  <= '0;
            gain_h       <= '0;
            vol_h        <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            mv_q         <= 1'b0;
            mch_q        <= 1'b0;
            pend         <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            aud_out_lft  <= '0;
            aud_out_rght <= '0;
            out_vld      <= 1'b0;
            busy         <= 1'b0;
            ovr          <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            pend    <= 1'b0;
            ovr     <= smpl_rdy && !accept_c;
            busy    <= (state != ST_IDLE) || pend;
            mv_q    <= (state == ST_SCALE);
            mch_q   <= cnt[0];

            // Band product from the previous cycle lands in its channel sum.
            if (mv_q) begin
                if (mch_q) begin
                    acc_r <= acc_r + ACC_W'(band_scaled);
                end else begin
                    acc_l <= acc_l + ACC_W'(band_scaled);
                end
            end

            if (pend) begin
                out_vld      <= 1'b1;
                aud_out_lft  <= hold_l;
                aud_out_rght <= hold_r;
            end

            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        band_lft_h  <= band_lft;
                        band_rght_h <= band_rght;
                        gain_h      <= POT_GAIN;
                        vol_h       <= POT_VOL;
                        acc_l       <= '0;
                        acc_r       <= '0;
                        cnt         <= '0;
                        state       <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    if (cnt == 4'(NUM_PROD - 1)) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    cnt   <= '0;
                    state <= ST_VOL;
                end
                ST_VOL: begin
                    if (cnt[0]) begin
                        hold_l <= prod[VOL_SHIFT+AUD_W-1:VOL_SHIFT];
                        cnt    <= '0;
                        state  <= ST_VDRAIN;
                    end else begin
                        cnt <= 4'd1;
                    end
                end
                ST_VDRAIN: begin
                    hold_r <= prod[VOL_SHIFT+AUD_W-1:VOL_SHIFT];
                    pend   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_scale_sched.sv
// Directed self-checking bench for eq_scale_sched (honours EQ_SAT_EN when defined).
module tb_eq_scale_sched;

    logic               clk;
    logic               rst_n;
    logic               smpl_rdy;
    logic [79:0]        band_lft;
    logic [79:0]        band_rght;
    logic [59:0]        POT_GAIN;
    logic [11:0]        POT_VOL;
    logic signed [15:0] aud_out_lft;
    logic signed [15:0] aud_out_rght;
    logic               out_vld;
    logic               busy;
    logic               ovr;

    int n_cmp = 0;
    int n_err = 0;

    eq_scale_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smpl_rdy     (smpl_rdy),
        .band_lft     (band_lft),
        .band_rght    (band_rght),
        .POT_GAIN     (POT_GAIN),
        .POT_VOL      (POT_VOL),
        .aud_out_lft  (aud_out_lft),
        .aud_out_rght (aud_out_rght),
        .out_vld      (out_vld),
        .busy         (busy),
        .ovr          (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uniform(input int l, input int r, input int g, input int v);
        for (int i = 0; i < 5; i++) begin
            band_lft[i*16 +: 16]  = 16'(l);
            band_rght[i*16 +: 16] = 16'(r);
            POT_GAIN[i*12 +: 12]  = 12'(g);
        end
        POT_VOL = 12'(v);
    endtask

    // Pulse smpl_rdy, scramble inputs, then wait (bounded) for out_vld and check it.
    task automatic run_sample(input string tag, input int exp_l, input int exp_r);
        int   lat;
        logic seen;
        logic busy_ok;
        smpl_rdy = 1'b1;
        step();
        smpl_rdy  = 1'b0;
        band_lft  = {$urandom, $urandom, 16'($urandom)};
        band_rght = {$urandom, $urandom, 16'($urandom)};
        POT_GAIN  = {$urandom, 28'($urandom)};
        POT_VOL   = 12'($urandom);
        lat = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step();
            if (out_vld) begin
                seen = 1'b1;
                lat  = i;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        check({tag, "_latency"}, lat, 15);
        check({tag, "_lft"}, int'(aud_out_lft), exp_l);
        check({tag, "_rght"}, int'(aud_out_rght), exp_r);
        check({tag, "_busy_vld"}, int'(busy), 1);
        check({tag, "_busy_span"}, int'(busy_ok), 1);
    endtask

    initial begin
        int exp32;
        int nv;
        rst_n = 1'b0;
        smpl_rdy = 1'b0;
        band_lft = '0;
        band_rght = '0;
        POT_GAIN = '0;
        POT_VOL = '0;
        step();
        step();
        check("rst_lft", int'(aud_out_lft), 0);
        check("rst_rght", int'(aud_out_rght), 0);
        check("rst_vld", int'(out_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(ovr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Unity gains, positive and negative inputs.
        set_uniform(100, 100, 2048, 4095);
        run_sample("pos100", 499, 499);
        step();
        check("pos100_vld_drop", int'(out_vld), 0);
        check("pos100_busy_drop", int'(busy), 0);
        check("pos100_hold", int'(aud_out_lft), 499);

        set_uniform(-100, -100, 2048, 4095);
        run_sample("neg100", -500, -500);
        step();

        // Large sum: saturate or wrap depending on build.
`ifdef EQ_SAT_EN
        exp32 = 32759;
`else
        exp32 = 18923;
`endif
        set_uniform(30000, 30000, 2048, 4095);
        run_sample("big30000", exp32, exp32);
        step();

        // Single band saturates on its own.
        set_uniform(1234, -777, 0, 4095);
        band_lft[15:0]  = 16'd30000;
        band_rght[15:0] = 16'd30000;
        POT_GAIN[11:0]  = 12'd4095;
        run_sample("lp_sat", 32759, 32759);
        step();

        // Distinct bands and gains per channel, half volume.
        band_lft  = {16'd500, 16'd400, 16'hF448, 16'd2000, 16'd1000};
        band_rght = {16'h8000, 16'h7FFF, 16'h0064, 16'h0000, 16'hFC18};
        POT_GAIN  = {12'd512, 12'd0, 12'd4095, 12'd1024, 12'd2048};
        POT_VOL   = 12'd2048;
        run_sample("mixed", -1937, -4497);

        // smpl_rdy in the out_vld cycle is dropped.
        smpl_rdy = 1'b1;
        set_uniform(7, 7, 2048, 4095);
        step();
        smpl_rdy = 1'b0;
        check("vld_cycle_ovr", int'(ovr), 1);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_vld) nv++;
        end
        check("vld_cycle_no_out", nv, 0);
        check("vld_cycle_ovr_clr", int'(ovr), 0);

        // Overrun five cycles into a sample.
        set_uniform(100, 100, 2048, 4095);
        smpl_rdy = 1'b1;
        step();
        smpl_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        set_uniform(-9000, 5000, 4095, 100);
        smpl_rdy = 1'b1;
        step();
        smpl_rdy = 1'b0;
        check("ovr_pulse", int'(ovr), 1);
        nv = 0;
        exp32 = 0;
        for (int i = 6; i <= 40; i++) begin
            step();
            if (out_vld) begin
                nv++;
                if (exp32 == 0) begin
                    exp32 = i;
                    check("ovr_lft", int'(aud_out_lft), 499);
                    check("ovr_rght", int'(aud_out_rght), 499);
                end
            end
        end
        check("ovr_latency", exp32, 15);
        check("ovr_one_vld", nv, 1);

        // Reset in the middle of SCALE aborts the sample.
        set_uniform(200, 200, 2048, 4095);
        smpl_rdy = 1'b1;
        step();
        smpl_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        rst_n = 1'b0;
        #1;
        check("abort_lft", int'(aud_out_lft), 0);
        check("abort_rght", int'(aud_out_rght), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_vld", int'(out_vld), 0);
        check("abort_ovr", int'(ovr), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_vld) nv++;
        end
        check("abort_no_vld", nv, 0);
        set_uniform(100, -100, 2048, 4095);
        run_sample("after_abort", 499, -500);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
